keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//   Upstream input stage of the microwave timer. Synchronises and debounces the 10-key one-hot keypad,
//   encodes each accepted press to a BCD digit, and shifts digits into a 3-digit M:SS entry buffer.
//   The buffer is the time preset consumed by the countdown/display stage. One digit per physical press.
// PARAMETERS
//   DEBOUNCE_CYCLES  3  consecutive stable samples required to accept a press (10 ms clk -> 30 ms)
//   RELEASE_CYCLES   3  consecutive all-zero samples required before the next press is armed
//   CNT_W            4  debounce counter width; must hold max(DEBOUNCE_CYCLES, RELEASE_CYCLES)
// PORTS
//   clk          in   1   system clock, rising edge
//   clearn       in   1   reset, synchronous, active-low
//   keypad       in  10   raw key lines, bit i = digit i, asynchronous to clk
//   entry_en     in   1   1 = accepted digits shift into buffer (timer idle); 0 = buffer frozen
//   clr_entry    in   1   synchronous clear of entry buffer (1-cycle pulse from control)
//   digit_valid  out  1   1-cycle pulse when a press is accepted
//   digit        out  4   BCD of last accepted key, held until next accept
//   minutes      out  4   buffer digit 2 (M)
//   sec_tens     out  4   buffer digit 1 (S tens)
//   sec_units    out  4   buffer digit 0 (S units)
//   time_valid   out  1   1 when buffer != 0:00 and sec_tens <= 5
//   multi_key    out  1   1-cycle pulse when >1 key seen in IDLE
// BEHAVIOUR
//   Reset (clearn=0 at edge): state=IDLE, counter=0, sync flops=0, all outputs 0.
//   Sync: keypad -> 2 flops -> keypad_s. Only keypad_s used below.
//   FSM
//     IDLE:     keypad_s==0 -> stay. Exactly one bit set -> capture one-hot, cnt=1, go DEBOUNCE.
//               >1 bit set -> pulse multi_key, go WAIT_REL (no digit).
//     DEBOUNCE: keypad_s==captured: if cnt==DEBOUNCE_CYCLES -> ACCEPT actions, go WAIT_REL; else cnt++.
//               keypad_s!=captured (bounce/other key) -> go IDLE, cnt=0, nothing accepted.
//     WAIT_REL: keypad_s!=0 -> cnt=0. keypad_s==0 -> cnt++; cnt reaches RELEASE_CYCLES -> IDLE, cnt=0.
//   ACCEPT actions (same edge): digit<=code, digit_valid<=1 for exactly one cycle;
//     if entry_en: {minutes,sec_tens,sec_units} <= {sec_tens,sec_units,code}; old minutes discarded.
//   Latency: key stable from edge 1 -> digit_valid high after edge DEBOUNCE_CYCLES+3 (6 for default).
//   Holding a key: exactly one accept; repeat needs release of RELEASE_CYCLES samples.
//   Buffer holds raw BCD, no normalisation (e.g. 9:99 legal storage; time_valid=0). Downstream clamps.
//   clr_entry=1: buffer <= 0:00 that edge. Simultaneous with ACCEPT: clear wins (no shift),
//     digit/digit_valid still update. FSM unaffected by clr_entry.
//   entry_en=0 during ACCEPT: digit_valid pulses, buffer unchanged.
//   clearn=0 mid-debounce or mid-hold: returns to IDLE; still-held key then re-debounces and is accepted
//     once (keypad_s restarts from 0 through sync).
//   time_valid registered, updates the cycle after buffer changes.
// STRUCTURE
//   microwave_defs.vh: FSM state localparams (IDLE=2'd0, DEBOUNCE=2'd1, WAIT_REL=2'd2), NUM_KEYS=10,
//     BCD width 4; shared with timer stage.
//   Sub-module keypad_encoder (combinational): 10-bit one-hot -> 4-bit code, is_one_hot, is_zero.
//   Top: sync flops, FSM + counter, entry shift register, time_valid register.
// TESTING
//   1 Press key 2 for 110 cycles, release -> one digit_valid after 6 edges, digit=2, buffer 0:02.
//   2 Keys 2,5,9,9,9 each held 110 / released 110 cycles -> buffer 9:99, 5 pulses, time_valid=0;
//     keys 1,3,0 -> buffer 1:30, time_valid=1.
//   3 Key 7 bounces (1,0,1 alternating cycles) then stable 10 cycles -> exactly one accept, digit=7.
//   4 Keys 3 and 4 together -> multi_key pulse, no digit_valid, buffer unchanged until full release.
//   5 entry_en=0, press 8 -> digit_valid=1, digit=8, buffer unchanged; clr_entry coincident with
//     accept of 6 -> buffer 0:00.
//   6 clearn=0 for one edge while key 5 in DEBOUNCE, key held -> all outputs 0, then one accept of 5.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// rtl/keypad_entry_pkg.sv - shared keypad/timer definitions: FSM states, key count, BCD width
package keypad_entry_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;

    // Encodings are shared with the countdown stage, so keep them fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

endpackage

// File: rtl/keypad_entry_encoder.sv
// rtl/keypad_entry_encoder.sv - combinational one-hot keypad to BCD encoder
//
// Ports:
//   i_keys        in   NUM_KEYS  synchronised key lines, bit i = digit i
//   o_code        out  BCD_W     index of the highest set bit (valid when o_is_one_hot)
//   o_is_one_hot  out  1         exactly one key is down
//   o_is_zero     out  1         no key is down
module keypad_entry_encoder
    import keypad_entry_pkg::*;
(
    input  logic [NUM_KEYS-1:0] i_keys,
    output logic [BCD_W-1:0]    o_code,
    output logic                o_is_one_hot,
    output logic                o_is_zero
);

    logic [3:0] w_count;

    always_comb begin
        o_code  = '0;
        w_count = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (i_keys[i]) begin
                o_code  = BCD_W'(i);
                w_count = w_count + 4'd1;
            end
        end
        o_is_one_hot = (w_count == 4'd1);
        o_is_zero    = (i_keys == '0);
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad sync/debounce, BCD encode and 3-digit M:SS entry buffer
//
// Ports:
//   i_clk          in   1   system clock, rising edge
//   i_clearn       in   1   synchronous active-low reset
//   i_keypad       in   10  raw key lines, asynchronous to i_clk
//   i_entry_en     in   1   1 = accepted digits shift into the buffer
//   i_clr_entry    in   1   clears the buffer to 0:00 (wins over a same-cycle shift)
//   o_digit_valid  out  1   one-cycle pulse per accepted press
//   o_digit        out  4   BCD of last accepted key, held
//   o_minutes      out  4   buffer digit 2
//   o_sec_tens     out  4   buffer digit 1
//   o_sec_units    out  4   buffer digit 0
//   o_time_valid   out  1   buffer != 0:00 and sec_tens <= 5 (registered)
//   o_multi_key    out  1   one-cycle pulse when more than one key is seen in IDLE
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int RELEASE_CYCLES  = 3,
    parameter int CNT_W           = 4
) (
    input  logic                i_clk,
    input  logic                i_clearn,
    input  logic [NUM_KEYS-1:0] i_keypad,
    input  logic                i_entry_en,
    input  logic                i_clr_entry,
    output logic                o_digit_valid,
    output logic [BCD_W-1:0]    o_digit,
    output logic [BCD_W-1:0]    o_minutes,
    output logic [BCD_W-1:0]    o_sec_tens,
    output logic [BCD_W-1:0]    o_sec_units,
    output logic                o_time_valid,
    output logic                o_multi_key
);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_keypad_s;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [NUM_KEYS-1:0] r_cap;
    logic [NUM_KEYS-1:0] w_cap_nxt;
    logic                w_accept;
    logic                w_multi;

    logic [BCD_W-1:0]    w_code;
    logic                w_one_hot;
    logic                w_is_zero;

    logic                r_digit_valid;
    logic [BCD_W-1:0]    r_digit;
    logic [BCD_W-1:0]    r_minutes;
    logic [BCD_W-1:0]    r_sec_tens;
    logic [BCD_W-1:0]    r_sec_units;
    logic                r_time_valid;
    logic                r_multi_key;

    keypad_entry_encoder u_encoder (
        .i_keys       (r_keypad_s),
        .o_code       (w_code),
        .o_is_one_hot (w_one_hot),
        .o_is_zero    (w_is_zero)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_clearn) begin
            r_sync1    <= '0;
            r_keypad_s <= '0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cap      <= '0;
        end else begin
            r_sync1    <= i_keypad;
            r_keypad_s <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cap      <= w_cap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_accept    = 1'b0;
        w_multi     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_is_zero) begin
                    if (w_one_hot) begin
                        w_cap_nxt   = r_keypad_s;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_multi     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT_REL;
                    end
                end
            end
            ST_DEBOUNCE: begin
                // Any change from the captured pattern (bounce or a second key) aborts the press.
                if (r_keypad_s == r_cap) begin
                    if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                        w_accept    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT_REL;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                // Release must be continuous; any key activity restarts the count.
                if (!w_is_zero) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == CNT_W'(RELEASE_CYCLES)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_clearn) begin
            r_digit_valid <= 1'b0;
            r_digit       <= '0;
            r_minutes     <= '0;
            r_sec_tens    <= '0;
            r_sec_units   <= '0;
            r_time_valid  <= 1'b0;
            r_multi_key   <= 1'b0;
        end else begin
            r_digit_valid <= w_accept;
            r_multi_key   <= w_multi;
            if (w_accept) begin
                r_digit <= w_code;
            end
            if (i_clr_entry) begin
                r_minutes   <= '0;
                r_sec_tens  <= '0;
                r_sec_units <= '0;
            end else if (w_accept && i_entry_en) begin
                r_minutes   <= r_sec_tens;
                r_sec_tens  <= r_sec_units;
                r_sec_units <= w_code;
            end
            // Judged on the current buffer, so it trails a buffer change by one cycle.
            r_time_valid <= ({r_minutes, r_sec_tens, r_sec_units} != '0) &&
                            (r_sec_tens <= BCD_W'(5));
        end
    end

    assign o_digit_valid = r_digit_valid;
    assign o_digit       = r_digit;
    assign o_minutes     = r_minutes;
    assign o_sec_tens    = r_sec_tens;
    assign o_sec_units   = r_sec_units;
    assign o_time_valid  = r_time_valid;
    assign o_multi_key   = r_multi_key;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard testbench for keypad_entry
module tb_keypad_entry;

    logic       clk = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       entry_en;
    logic       clr_entry;
    logic       digit_valid;
    logic [3:0] digit;
    logic [3:0] minutes;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       time_valid;
    logic       multi_key;

    always #5 clk = ~clk;

    keypad_entry dut (
        .i_clk         (clk),
        .i_clearn      (clearn),
        .i_keypad      (keypad),
        .i_entry_en    (entry_en),
        .i_clr_entry   (clr_entry),
        .o_digit_valid (digit_valid),
        .o_digit       (digit),
        .o_minutes     (minutes),
        .o_sec_tens    (sec_tens),
        .o_sec_units   (sec_units),
        .o_time_valid  (time_valid),
        .o_multi_key   (multi_key)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] u;
    } exp_t;

    exp_t       exp_q[$];
    int         multi_exp = 0;
    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [3:0] m_m = 0, m_t = 0, m_u = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per digit_valid pulse.
    always @(negedge clk) begin
        if (digit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_digit_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digit", {28'd0, digit}, {28'd0, e.d});
                check("buffer", {20'd0, minutes, sec_tens, sec_units}, {20'd0, e.m, e.t, e.u});
            end
        end
        if (multi_key === 1'b1) begin
            if (multi_exp == 0) check("unexpected_multi_key", 32'd1, 32'd0);
            else begin
                multi_exp--;
                check("multi_key_pulse", {31'd0, multi_key}, 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of one accepted press; clr wins over the shift.
    task automatic expect_accept(input logic [3:0] code, input logic en, input logic clr);
        if (clr) begin
            m_m = 0; m_t = 0; m_u = 0;
        end else if (en) begin
            m_m = m_t; m_t = m_u; m_u = code;
        end
        exp_q.push_back({code, m_m, m_t, m_u});
    endtask

    task automatic press(input int k, input int hold, input int rel);
        expect_accept(4'(k), entry_en, 1'b0);
        keypad = 10'd1 << k;
        tick(hold);
        keypad = '0;
        tick(rel);
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        check({name, "_multi"}, multi_exp, 0);
    endtask

    initial begin
        int seq[8];
        seq = '{2, 5, 9, 9, 9, 1, 3, 0};
        clearn = 0; keypad = '0; entry_en = 1; clr_entry = 0;
        tick(3);
        check("rst_digit_valid", {31'd0, digit_valid}, 0);
        check("rst_digit", {28'd0, digit}, 0);
        check("rst_buffer", {20'd0, minutes, sec_tens, sec_units}, 0);
        check("rst_time_valid", {31'd0, time_valid}, 0);
        check("rst_multi_key", {31'd0, multi_key}, 0);
        clearn = 1;
        tick(2);

        // 1: single press, latency check
        expect_accept(4'd2, 1'b1, 1'b0);
        keypad = 10'd1 << 2;
        tick(5);
        check("lat_edge5", {31'd0, digit_valid}, 0);
        tick(1);
        check("lat_edge6", {31'd0, digit_valid}, 1);
        tick(104);
        keypad = '0;
        tick(110);
        check_drained("t1_drain");
        check("t1_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h002);

        // 2: sequence to 9:99 then 1:30 (clear first so the sequence starts from 0:00)
        clr_entry = 1; tick(1); clr_entry = 0; m_m = 0; m_t = 0; m_u = 0;
        tick(2);
        for (int i = 0; i < 5; i++) press(seq[i], 110, 110);
        check_drained("t2a_drain");
        check("t2a_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h999);
        check("t2a_time_valid", {31'd0, time_valid}, 0);
        for (int i = 5; i < 8; i++) press(seq[i], 110, 110);
        check_drained("t2b_drain");
        check("t2b_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h130);
        check("t2b_time_valid", {31'd0, time_valid}, 1);

        // 3: bouncing key 7, then stable
        expect_accept(4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            keypad = (i % 2 == 0) ? (10'd1 << 7) : 10'd0;
            tick(1);
        end
        keypad = 10'd1 << 7;
        tick(10);
        keypad = '0;
        tick(110);
        check_drained("t3_drain");
        check("t3_digit", {28'd0, digit}, 7);
        check("t3_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h307);

        // 4: two keys together
        multi_exp = 1;
        keypad = (10'd1 << 3) | (10'd1 << 4);
        tick(110);
        check("t4_buffer_held", {20'd0, minutes, sec_tens, sec_units}, 12'h307);
        keypad = '0;
        tick(110);
        check_drained("t4_drain");
        check("t4_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h307);

        // 5: frozen buffer, then clear coincident with accept
        entry_en = 0;
        press(8, 110, 110);
        check_drained("t5a_drain");
        check("t5a_digit", {28'd0, digit}, 8);
        check("t5a_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h307);
        entry_en = 1;
        expect_accept(4'd6, 1'b1, 1'b1);
        keypad = 10'd1 << 6;
        tick(5);
        clr_entry = 1;
        tick(1);
        clr_entry = 0;
        tick(104);
        keypad = '0;
        tick(110);
        check_drained("t5b_drain");
        check("t5b_digit", {28'd0, digit}, 6);
        check("t5b_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h000);
        check("t5b_time_valid", {31'd0, time_valid}, 0);

        // 6: reset mid-debounce with key held
        m_m = 0; m_t = 0; m_u = 0;
        expect_accept(4'd5, 1'b1, 1'b0);
        keypad = 10'd1 << 5;
        tick(4);
        clearn = 0;
        tick(1);
        clearn = 1;
        check("t6_rst_digit", {28'd0, digit}, 0);
        check("t6_rst_buffer", {20'd0, minutes, sec_tens, sec_units}, 0);
        check("t6_rst_valid", {29'd0, digit_valid, time_valid, multi_key}, 0);
        tick(110);
        keypad = '0;
        tick(110);
        check_drained("t6_drain");
        check("t6_digit", {28'd0, digit}, 5);
        check("t6_buffer", {20'd0, minutes, sec_tens, sec_units}, 12'h005);
        check("t6_time_valid", {31'd0, time_valid}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
